// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier:
// FSM state encoding, operand extension and Booth pair decode values.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Radix-2 Booth decode of {Q[0], q_m1}
  localparam logic [1:0] BOOTH_ADD    = 2'b01;
  localparam logic [1:0] BOOTH_SUB    = 2'b10;
  localparam logic [1:0] BOOTH_NOP_00 = 2'b00;
  localparam logic [1:0] BOOTH_NOP_11 = 2'b11;

  // Extra top bit used when widening an operand by one bit: sign copy or zero.
  function automatic logic ext_msb(input logic msb, input logic is_signed);
    return is_signed & msb;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of Mx into A,
// then arithmetic right shift of {A,Q,q_m1} by one bit.
module booth_step
  import booth_pkg::*;
#(
  parameter int EW = 65
) (
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] q,
  input  logic          q_m1,
  input  logic [EW-1:0] mx,
  output logic [EW-1:0] a_next,
  output logic [EW-1:0] q_next,
  output logic          q_m1_next
);

  logic [EW-1:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      BOOTH_ADD:                  sum = a + mx;
      BOOTH_SUB:                  sum = a - mx;
      BOOTH_NOP_00, BOOTH_NOP_11: sum = a;
    endcase
    a_next    = {sum[EW-1], sum[EW-1:1]};
    q_next    = {sum[0], q[EW-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Iterative Booth multiplier, one step per clock: product valid EW+1 cycles after accept,
// held in DONE until out_ready; in_ready only in IDLE so a stalled consumer blocks new operands.
module seq_booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int EW = WIDTH + 1;
  localparam int CW = $clog2(EW + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(EW - 1);

  state_e             state_q, state_d;
  logic [EW-1:0]      a_q, a_d, q_q, q_d, m_q, m_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [EW-1:0]      a_n, q_n;
  logic               qm1_n;

  booth_step #(.EW(EW)) u_step (
    .a         (a_q),
    .q         (q_q),
    .q_m1      (qm1_q),
    .mx        (m_q),
    .a_next    (a_n),
    .q_next    (q_n),
    .q_m1_next (qm1_n)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = {ext_msb(multiplicand[WIDTH-1], is_signed), multiplicand};
          q_d     = {ext_msb(multiplier[WIDTH-1], is_signed), multiplier};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d   = a_n;
        q_d   = q_n;
        qm1_d = qm1_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          // Low 2*WIDTH bits of {A,Q} after the final shift
          prod_d  = {a_n[WIDTH-2:0], q_n};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      qm1_q       <= 1'b0;
      cnt_q       <= '0;
      prod_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      qm1_q       <= qm1_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = prod_q;

endmodule
